// File: rtl/program_loader.sv
// Streams instruction words into imem, flushes, then releases the core to fetch from address 0.
// Optional running XOR checksum of loaded words, enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wd,
  output logic                  core_run,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH:0] DepthL    = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [7:0]          FlushLast = 8'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [7:0]            flush_cnt_q, flush_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  done_q, done_d;
  logic                  len_err_q, len_err_d;
  logic                  hs;
  logic                  sum_clr;

  assign in_ready = (state_q == StLoad);
  assign hs       = in_ready & in_valid;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    len_d       = len_q;
    flush_cnt_d = flush_cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wd_d        = wd_q;
    done_d      = 1'b0;
    len_err_d   = len_err_q;
    sum_clr     = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (start) begin
          if (load_len > DepthL) begin
            // Rejected reload from RUN drops to IDLE with the core held.
            len_err_d = 1'b1;
            state_d   = StIdle;
          end else if (load_len == '0) begin
            sum_clr     = 1'b1;
            flush_cnt_d = '0;
            state_d     = StFlush;
          end else begin
            sum_clr   = 1'b1;
            len_err_d = 1'b0;
            wr_cnt_d  = '0;
            len_d     = load_len;
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        if (hs) begin
          we_d     = 1'b1;
          addr_d   = wr_cnt_q[ADDR_WIDTH-1:0];
          wd_d     = in_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == len_q - 1'b1) begin
            flush_cnt_d = '0;
            state_d     = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          done_d  = 1'b1;
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      len_q       <= '0;
      flush_cnt_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      len_q       <= len_d;
      flush_cnt_q <= flush_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (sum_clr) begin
      sum_d = '0;
    end else if (hs) begin
      sum_d = sum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  logic unused_sum_clr;
  assign unused_sum_clr = sum_clr;
  assign checksum       = '0;
`endif

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign core_run  = (state_q == StRun);
  assign busy      = (state_q == StLoad) | (state_q == StFlush);
  assign done      = done_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected imem writes are queued as words are
// driven and checked by a write monitor; scenario tasks check control outputs inline.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  load_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        len_err;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q[$];
  logic [6:0]  exp_addr;
  logic [31:0] exp_sum;

  program_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_len (load_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .imem_we  (imem_we),
    .imem_addr(imem_addr),
    .imem_wd  (imem_wd),
    .core_run (core_run),
    .busy     (busy),
    .done     (done),
    .len_err  (len_err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // Write monitor: every imem write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      logic [37:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", imem_addr,
                 imem_wd);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wd} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", imem_addr,
                   imem_wd, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Applies start for one edge and updates the model for a legal start.
  task automatic do_start(input logic [6:0] len);
    start    = 1'b1;
    load_len = len;
    if (len <= 7'd64) begin
      exp_addr = '0;
      exp_sum  = '0;
    end
    step();
    start = 1'b0;
  endtask

  // One cycle of source activity; the word is expected in imem only if v is set.
  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    if (v) begin
      exp_q.push_back({exp_addr[5:0], d});
      exp_addr = exp_addr + 7'd1;
      exp_sum  = exp_sum ^ d;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (!core_run && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic check_run_entry(input string name);
    int n;
    wait_run(n);
    total++;
    if (n !== 5 || done !== 1'b1) begin
      bad++;
      $display("FAIL %s_flush: got flush=%0d done=%b, required flush=5 done=1", name, n, done);
    end
    step();
    total++;
    if (done !== 1'b0 || core_run !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_run: got done=%b core_run=%b busy=%b, required 0 1 0", name, done,
               core_run, busy);
    end
  endtask

  task automatic check_sum(input string name);
    logic [31:0] want;
`ifdef LOADER_CHECKSUM_EN
    want = exp_sum;
`else
    want = 32'h0;
`endif
    total++;
    if (checksum !== want) begin
      bad++;
      $display("FAIL %s_checksum: got %h, required %h", name, checksum, want);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wd, core_run, busy, done, len_err, checksum} !== '0)
    begin
      bad++;
      $display("FAIL %s_zero: got rdy=%b we=%b a=%0d wd=%h run=%b busy=%b done=%b err=%b cs=%h, required all 0",
               name, in_ready, imem_we, imem_addr, imem_wd, core_run, busy, done, len_err,
               checksum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
    repeat (2) step();
    rst = 1'b0;
    step();
    check_zero_outputs("post_reset");
  endtask

  task automatic test_basic();
    do_start(7'd3);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || core_run !== 1'b0) begin
      bad++;
      $display("FAIL basic_load_state: got rdy=%b busy=%b run=%b, required 1 1 0", in_ready,
               busy, core_run);
    end
    drive(1'b1, 32'h20080005);
    drive(1'b1, 32'h20090007);
    drive(1'b1, 32'h01095020);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_flush_entry: got rdy=%b busy=%b, required 0 1", in_ready, busy);
    end
    check_run_entry("basic");
    check_sum("basic");
    check_drained("basic");
  endtask

  task automatic test_gaps_reload();
    logic [6:0] pat;
    pat = 7'b1011001;  // consumed LSB first: 1,0,0,1,1,0,1
    do_start(7'd4);
    total++;
    if (core_run !== 1'b0) begin
      bad++;
      $display("FAIL gaps_hold: got core_run=%b, required 0", core_run);
    end
    for (int i = 0; i < 7; i++) drive(pat[i], 32'hA000_0000 + i);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL gaps_ready: got in_ready=%b, required 0", in_ready);
    end
    check_run_entry("gaps");
    check_sum("gaps");
    check_drained("gaps");
  endtask

  task automatic test_full_depth();
    do_start(7'd64);
    for (int i = 0; i < 64; i++) drive(1'b1, $urandom());
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL full_flush_entry: got rdy=%b busy=%b, required 0 1", in_ready, busy);
    end
    check_run_entry("full");
    check_sum("full");
    check_drained("full");
  endtask

  task automatic test_len_err();
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    do_start(7'd65);
    total++;
    if (len_err !== 1'b1 || core_run !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL len_err: got err=%b run=%b busy=%b rdy=%b, required 1 0 0 0", len_err,
               core_run, busy, in_ready);
    end
    repeat (3) step();
    in_valid = 1'b0;
    check_drained("len_err");
  endtask

  task automatic test_zero_len();
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    do_start(7'd0);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_flush: got busy=%b rdy=%b, required 1 0", busy, in_ready);
    end
    check_run_entry("zero");
    check_sum("zero");
    check_drained("zero");
  endtask

  task automatic test_reload_ignore_start();
    do_start(7'd2);
    total++;
    if (core_run !== 1'b0) begin
      bad++;
      $display("FAIL reload_hold: got core_run=%b, required 0", core_run);
    end
    start    = 1'b1;
    load_len = 7'd5;
    drive(1'b1, 32'h0BAD_F00D);
    drive(1'b1, 32'h600D_CAFE);
    start = 1'b0;
    check_run_entry("reload");
    check_sum("reload");
    check_drained("reload");
  endtask

  task automatic test_async_reset();
    do_start(7'd5);
    drive(1'b1, 32'h1111_1111);
    drive(1'b1, 32'h2222_2222);
    drive(1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    check_drained("async_reset");
    step();
    rst = 1'b0;
    step();
    do_start(7'd1);
    drive(1'b1, 32'h3333_3333);
    check_run_entry("after_reset");
    check_sum("after_reset");
    check_drained("after_reset");
  endtask

  initial begin
    start    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    exp_addr = '0;
    exp_sum  = '0;
    test_reset();
    test_basic();
    test_gaps_reload();
    test_full_depth();
    test_len_err();
    test_zero_len();
    test_reload_ignore_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
